// File: rtl/ram64x16_arbiter.sv
// ram64x16_arbiter
//   Shares one external 64x16 single-port RAM (registered address and
//   registered output, both clocked by the system clock) between two
//   requesters, A and B. After reset the whole RAM is swept to CLEAR_VALUE.
//   After the sweep, one command per cycle is granted by round-robin, and read
//   data is returned to the issuer with a fixed latency of READ_LATENCY cycles.
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata    requester A command (held until a_gnt)
//   a_gnt, a_rvalid              A accepted this cycle / rdata is A's result
//   b_*                          same as A, for requester B
//   rdata                        shared read data (qualified by *_rvalid)
//   ram_data/ram_address/ram_we  driven straight onto the RAM pins
//   ram_q                        RAM output register
//   init_done                    high once the clear sweep has finished
module ram64x16_arbiter #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  parameter bit                    INIT_ENABLE  = 1'b1,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);

  // One extra counter bit so the terminal count is an ordinary compare.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    last_b_q;      // 1: B won the most recent grant
  logic                    gnt_a, gnt_b;
  logic                    rd_issue;
  logic [READ_LATENCY-1:0] vld_p;         // read in flight, per cycle of age
  logic [READ_LATENCY-1:0] own_p;         // owner of that read, 1 = B

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    ram_we      = 1'b0;
    ram_address = a_addr;
    ram_data    = a_wdata;
    if (reset) begin
      // Outputs are forced quiet for the whole reset cycle, before the
      // registers have had an edge to clear.
      ram_address = '0;
      ram_data    = '0;
    end else if (state_q == S_INIT) begin
      ram_we      = 1'b1;
      ram_address = cnt_q[ADDR_WIDTH-1:0];
      ram_data    = CLEAR_VALUE;
      cnt_d       = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = S_ARB;
      end
    end else begin
      // On a tie the requester that did not win last time is served.
      gnt_a = a_req & (~b_req | last_b_q);
      gnt_b = b_req & (~a_req | ~last_b_q);
      if (gnt_b) begin
        ram_we      = b_we;
        ram_address = b_addr;
        ram_data    = b_wdata;
      end else if (gnt_a) begin
        ram_we      = a_we;
        ram_address = a_addr;
        ram_data    = a_wdata;
      end
    end
  end

  assign rd_issue = (gnt_a & ~a_we) | (gnt_b & ~b_we);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT_ENABLE ? S_INIT : S_ARB;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      vld_p    <= '0;
      own_p    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_a | gnt_b) begin
        last_b_q <= gnt_b;
      end
      // Read tracking: stage 0 is the RAM address register, the last stage
      // lines up with the RAM output register.
      vld_p[0] <= rd_issue;
      own_p[0] <= gnt_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        own_p[i] <= own_p[i-1];
      end
    end
  end

  assign a_gnt     = gnt_a;
  assign b_gnt     = gnt_b;
  assign a_rvalid  = ~reset & vld_p[READ_LATENCY-1] & ~own_p[READ_LATENCY-1];
  assign b_rvalid  = ~reset & vld_p[READ_LATENCY-1] &  own_p[READ_LATENCY-1];
  assign rdata     = ram_q;
  assign init_done = ~reset & (state_q == S_ARB);

endmodule

// File: tb/tb_ram64x16_arbiter.sv
// Testbench for ram64x16_arbiter: a model of the external RAM, a
// transaction-level reference model compared every cycle, directed scenarios
// with literal expectations, a randomized traffic phase, and a second instance
// built with the clear sweep disabled.
module tb_ram64x16_arbiter;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (defaults, clear sweep enabled) ----------------
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we, init_done;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  ram64x16_arbiter dut0 (
    .clock(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_data(ram_data), .ram_address(ram_address),
    .ram_we(ram_we), .ram_q(ram_q), .init_done(init_done)
  );

  // RAM with registered address/data/we and a registered output.
  logic [DW-1:0] ram0 [64];
  logic [AW-1:0] ra0;
  always @(posedge clk) begin
    if (ram_we) ram0[ram_address] <= ram_data;
    ra0   <= ram_address;
    ram_q <= ram0[ra0];
  end

  // ---------------- DUT 1 (clear sweep disabled) ----------------
  logic          c_reset = 1'b1;
  logic          c_a_req = 1'b0, c_a_we = 1'b0, c_b_req = 1'b0, c_b_we = 1'b0;
  logic [AW-1:0] c_a_addr = '0, c_b_addr = '0;
  logic [DW-1:0] c_a_wdata = '0, c_b_wdata = '0;
  logic          c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid, c_ram_we, c_init_done;
  logic [DW-1:0] c_rdata, c_ram_data, c_ram_q;
  logic [AW-1:0] c_ram_address;

  ram64x16_arbiter #(.INIT_ENABLE(1'b0)) dut1 (
    .clock(clk), .reset(c_reset),
    .a_req(c_a_req), .a_we(c_a_we), .a_addr(c_a_addr), .a_wdata(c_a_wdata),
    .a_gnt(c_a_gnt), .a_rvalid(c_a_rvalid),
    .b_req(c_b_req), .b_we(c_b_we), .b_addr(c_b_addr), .b_wdata(c_b_wdata),
    .b_gnt(c_b_gnt), .b_rvalid(c_b_rvalid),
    .rdata(c_rdata), .ram_data(c_ram_data), .ram_address(c_ram_address),
    .ram_we(c_ram_we), .ram_q(c_ram_q), .init_done(c_init_done)
  );

  logic [DW-1:0] ram1 [64];
  logic [AW-1:0] ra1;
  always @(posedge clk) begin
    if (c_ram_we) ram1[c_ram_address] <= c_ram_data;
    ra1     <= c_ram_address;
    c_ram_q <= ram1[ra1];
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
  endfunction

  // Reference model for DUT 0: a clear sweep of 64 words, then at most one
  // transfer per cycle chosen by round-robin, reads answered two cycles later
  // with the memory contents as of the grant.
  typedef struct { int due; bit own_b; logic [DW-1:0] d; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] mmem [64];
  int            cyc       = 0;
  int            init_left = 64;
  bit            last_b    = 1'b1;
  bit            a_taken   = 1'b0, b_taken = 1'b0;
  bit            ea_g, eb_g, ea_v, eb_v, e_we, e_done, chk_ad, w_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rd;

  always @(negedge clk) begin
    cyc++;
    a_taken = 1'b0; b_taken = 1'b0;
    ea_g = 1'b0; eb_g = 1'b0; ea_v = 1'b0; eb_v = 1'b0;
    e_we = 1'b0; e_done = 1'b0; chk_ad = 1'b1;
    e_addr = '0; e_data = '0; e_rd = '0;
    if (reset) begin
      init_left = 64;
      last_b    = 1'b1;
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ea_v = !pend[0].own_b;
        eb_v = pend[0].own_b;
        e_rd = pend[0].d;
        void'(pend.pop_front());
      end
      if (init_left > 0) begin
        e_we   = 1'b1;
        e_addr = AW'(64 - init_left);
        e_data = 16'h0000;
        mmem[e_addr] = e_data;
        init_left--;
      end else begin
        e_done = 1'b1;
        if (a_req && (!b_req || last_b)) ea_g = 1'b1;
        else if (b_req)                  eb_g = 1'b1;
        if (ea_g || eb_g) begin
          w_we   = ea_g ? a_we    : b_we;
          e_addr = ea_g ? a_addr  : b_addr;
          e_data = ea_g ? a_wdata : b_wdata;
          e_we   = w_we;
          last_b = eb_g;
          if (w_we) mmem[e_addr] = e_data;
          else pend.push_back('{due: cyc + 2, own_b: eb_g, d: mmem[e_addr]});
        end else begin
          chk_ad = 1'b0;
        end
        a_taken = ea_g;
        b_taken = eb_g;
      end
    end
    chk("a_gnt",     32'(a_gnt),     32'(ea_g));
    chk("b_gnt",     32'(b_gnt),     32'(eb_g));
    chk("a_rvalid",  32'(a_rvalid),  32'(ea_v));
    chk("b_rvalid",  32'(b_rvalid),  32'(eb_v));
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("ram_we",    32'(ram_we),    32'(e_we));
    if (chk_ad) begin
      chk("ram_address", 32'(ram_address), 32'(e_addr));
      chk("ram_data",    32'(ram_data),    32'(e_data));
    end
    if (ea_v || eb_v) chk("rdata", 32'(rdata), 32'(e_rd));
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(bit req, bit we, int addr, int data);
    a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = DW'(data);
  endtask

  task automatic set_b(bit req, bit we, int addr, int data);
    b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = DW'(data);
  endtask

  logic [DW-1:0] pv [3];

  initial begin
    repeat (3) next_cycle();

    // Clear sweep with A requesting the whole time.
    set_a(1, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_we",   32'(ram_we),      1);
      chk("init_addr", 32'(ram_address), i);
      chk("init_data", 32'(ram_data),    0);
      chk("init_agnt", 32'(a_gnt),       0);
      next_cycle();
    end
    @(negedge clk);
    chk("init_done_rise", 32'(init_done), 1);
    chk("first_agnt",     32'(a_gnt),     1);
    next_cycle();
    set_a(0, 0, 0, 0);
    repeat (3) next_cycle();

    // A writes then immediately reads the same word.
    set_a(1, 1, 5, 'hBEEF);
    next_cycle();
    set_a(1, 0, 5, 0);
    next_cycle();
    set_a(0, 0, 0, 0);
    @(negedge clk);
    chk("beef_early_rvalid", 32'(a_rvalid), 0);
    next_cycle();
    @(negedge clk);
    chk("beef_rvalid",   32'(a_rvalid), 1);
    chk("beef_rdata",    32'(rdata),    32'h0000BEEF);
    chk("beef_b_rvalid", 32'(b_rvalid), 0);
    repeat (3) next_cycle();

    // Contention: preload, then both read continuously for six cycles.
    set_a(1, 1, 1, 1);
    next_cycle();
    set_a(0, 0, 0, 0);
    set_b(1, 1, 2, 2);
    next_cycle();
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
      end
      @(negedge clk);
      chk("rr_agnt", 32'(a_gnt), 32'(k < 6 && k % 2 == 0));
      chk("rr_bgnt", 32'(b_gnt), 32'(k < 6 && k % 2 == 1));
      if (k >= 2) begin
        chk("rr_arvalid", 32'(a_rvalid), 32'(k % 2 == 0));
        chk("rr_brvalid", 32'(b_rvalid), 32'(k % 2 == 1));
        chk("rr_rdata",   32'(rdata),    (k % 2 == 0) ? 1 : 2);
      end
      next_cycle();
    end

    // B: three writes then three back-to-back reads.
    for (int j = 0; j < 3; j++) begin
      pv[j] = DW'($urandom);
      set_b(1, 1, 10 + j, int'(pv[j]));
      next_cycle();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 3) set_b(1, 0, 10 + k, 0);
      else       set_b(0, 0, 0, 0);
      @(negedge clk);
      if (k >= 2 && k < 5) begin
        chk("pipe_brvalid", 32'(b_rvalid), 1);
        chk("pipe_rdata",   32'(rdata),    32'(pv[k-2]));
      end
      if (k == 5) chk("pipe_brvalid_end", 32'(b_rvalid), 0);
      next_cycle();
    end

    // Randomized traffic; each requester holds its command until granted.
    for (int n = 0; n < 2000; n++) begin
      if (!a_req || a_taken) begin
        if ($urandom_range(0, 9) < 6) set_a(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), int'($urandom));
        else set_a(0, 0, 0, 0);
      end
      if (!b_req || b_taken) begin
        if ($urandom_range(0, 9) < 6) set_b(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), int'($urandom));
        else set_b(0, 0, 0, 0);
      end
      next_cycle();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) next_cycle();

    // Reset the cycle after a read is granted.
    set_a(1, 1, 7, 'h1234);
    next_cycle();
    set_a(1, 0, 7, 0);
    next_cycle();
    set_a(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_arvalid", 32'(a_rvalid), 0);
    chk("rst_we",      32'(ram_we),   0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_arvalid_after", 32'(a_rvalid),    0);
    chk("reinit_we",         32'(ram_we),      1);
    chk("reinit_addr",       32'(ram_address), 0);
    repeat (64) next_cycle();
    set_a(1, 0, 7, 0);
    @(negedge clk);
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_agnt", 32'(a_gnt),     1);
    next_cycle();
    set_a(0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("cleared_rvalid", 32'(a_rvalid), 1);
    chk("cleared_rdata",  32'(rdata),    0);
    next_cycle();

    // Second instance: no sweep, pending B write granted right away.
    c_b_req = 1'b1; c_b_we = 1'b1; c_b_addr = AW'(9); c_b_wdata = 16'hCAFE;
    @(negedge clk);
    chk("c_rst_we",   32'(c_ram_we),    0);
    chk("c_rst_bgnt", 32'(c_b_gnt),     0);
    chk("c_rst_done", 32'(c_init_done), 0);
    next_cycle();
    c_reset = 1'b0;
    @(negedge clk);
    chk("c_done",    32'(c_init_done),   1);
    chk("c_bgnt",    32'(c_b_gnt),       1);
    chk("c_wr_we",   32'(c_ram_we),      1);
    chk("c_wr_addr", 32'(c_ram_address), 9);
    chk("c_wr_data", 32'(c_ram_data),    32'h0000CAFE);
    next_cycle();
    c_b_we = 1'b0;
    @(negedge clk);
    chk("c_rd_bgnt", 32'(c_b_gnt),  1);
    chk("c_rd_we",   32'(c_ram_we), 0);
    next_cycle();
    c_b_req = 1'b0;
    @(negedge clk);
    chk("c_idle_we",      32'(c_ram_we),   0);
    chk("c_early_rvalid", 32'(c_b_rvalid), 0);
    next_cycle();
    @(negedge clk);
    chk("c_brvalid", 32'(c_b_rvalid), 1);
    chk("c_arvalid", 32'(c_a_rvalid), 0);
    chk("c_rdata",   32'(c_rdata),    32'h0000CAFE);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
